// File: rtl/btn_scan_pkg.sv
// rtl/btn_scan_pkg.sv - shared types and constants for the button scan controller
package btn_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam int SETTLE_CYCLES = 2;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-stage synchronizer for an asynchronous input vector
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_scan_ctrl.sv
// rtl/btn_scan_ctrl.sv - round-robin debouncer sharing one evaluator across N_BTN buttons
// Optional event latch (evt_ack/evt_pend) enabled by defining BTN_EVENT_LATCH_EN.
module btn_scan_ctrl
    import btn_scan_pkg::*;
#(
    parameter int N_BTN    = 4,
    parameter int TICK_DIV = 1000,
    parameter int DB_CNT   = 8,
    localparam int IW      = width_of(N_BTN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [N_BTN-1:0] raw,
    output logic [N_BTN-1:0] clean,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_pulse,
    output logic [IW-1:0]    scan_idx,
    output logic             running
`ifdef BTN_EVENT_LATCH_EN
    ,
    input  logic [N_BTN-1:0] evt_ack,
    output logic [N_BTN-1:0] evt_pend
`endif
);

    localparam int CW = width_of(DB_CNT);
    localparam int PW = width_of(TICK_DIV);
    localparam int SW = width_of(SETTLE_CYCLES);

    state_t           state;
    state_t           next_state;
    logic [SW-1:0]    settle_cnt;
    logic [PW-1:0]    prescaler;
    logic [CW-1:0]    cnt [N_BTN];
    logic [N_BTN-1:0] sraw;
    logic             scan_active;
    logic             tick;

    sync_2ff #(.WIDTH(N_BTN)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (raw),
        .q     (sraw)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            state   <= next_state;
            running <= (next_state == RUN);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (en) next_state = SETTLE;
            SETTLE: begin
                if (!en)
                    next_state = IDLE;
                else if (settle_cnt == SW'(SETTLE_CYCLES - 1))
                    next_state = RUN;
            end
            RUN:     if (!en) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Dropping en in RUN suppresses that cycle's evaluation and clears the scan.
    always_comb begin
        scan_active = 1'b0;
        tick        = 1'b0;
        if (state == RUN && en) begin
            scan_active = 1'b1;
            tick        = (prescaler == PW'(TICK_DIV - 1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt    <= '0;
            prescaler     <= '0;
            scan_idx      <= '0;
            clean         <= '0;
            press         <= '0;
            release_pulse <= '0;
            for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
        end else begin
            press         <= '0;
            release_pulse <= '0;
            settle_cnt    <= (state == SETTLE && next_state == SETTLE) ? settle_cnt + SW'(1) : '0;
            if (!scan_active) begin
                prescaler <= '0;
                scan_idx  <= '0;
                for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
            end else begin
                prescaler <= tick ? '0 : prescaler + PW'(1);
                if (tick) begin
                    scan_idx <= (scan_idx == IW'(N_BTN - 1)) ? '0 : scan_idx + IW'(1);
                    // Only the visited channel's counter moves; an agreeing sample restarts it.
                    if (sraw[scan_idx] == clean[scan_idx]) begin
                        cnt[scan_idx] <= '0;
                    end else if (cnt[scan_idx] == CW'(DB_CNT - 1)) begin
                        cnt[scan_idx]   <= '0;
                        clean[scan_idx] <= sraw[scan_idx];
                        if (sraw[scan_idx])
                            press[scan_idx] <= 1'b1;
                        else
                            release_pulse[scan_idx] <= 1'b1;
                    end else begin
                        cnt[scan_idx] <= cnt[scan_idx] + CW'(1);
                    end
                end
            end
        end
    end

`ifdef BTN_EVENT_LATCH_EN
    // A press in the same cycle as an ack keeps the event pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            evt_pend <= '0;
        else
            evt_pend <= (evt_pend & ~evt_ack) | press;
    end
`endif

endmodule

// File: tb/tb_btn_scan_ctrl.sv
// tb/tb_btn_scan_ctrl.sv - directed self-checking bench for btn_scan_ctrl
module tb_btn_scan_ctrl;

    localparam int N_BTN    = 4;
    localparam int TICK_DIV = 4;
    localparam int DB_CNT   = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] raw;
    logic [3:0] clean;
    logic [3:0] press;
    logic [3:0] release_pulse;
    logic [1:0] scan_idx;
    logic       running;
`ifdef BTN_EVENT_LATCH_EN
    logic [3:0] evt_ack;
    logic [3:0] evt_pend;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int rc;
    int coincide;
    int press_cnt [4];
    int rel_cnt   [4];
    int press_at  [4];
    int rel_at    [4];

    always #5 clk = ~clk;

    btn_scan_ctrl #(
        .N_BTN    (N_BTN),
        .TICK_DIV (TICK_DIV),
        .DB_CNT   (DB_CNT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .raw           (raw),
        .clean         (clean),
        .press         (press),
        .release_pulse (release_pulse),
        .scan_idx      (scan_idx),
        .running       (running)
`ifdef BTN_EVENT_LATCH_EN
        ,
        .evt_ack       (evt_ack),
        .evt_pend      (evt_pend)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        rc++;
        for (int i = 0; i < 4; i++) begin
            if (press[i]) begin
                press_cnt[i]++;
                press_at[i] = rc;
            end
            if (release_pulse[i]) begin
                rel_cnt[i]++;
                rel_at[i] = rc;
            end
        end
        if ((|press) && (|release_pulse)) coincide++;
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b1;
        raw      = 4'b0010;
        rc       = 0;
        coincide = 0;
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
            press_at[i]  = 0;
            rel_at[i]    = 0;
        end
`ifdef BTN_EVENT_LATCH_EN
        evt_ack = 4'b0000;
`endif
        repeat (3) @(negedge clk);
        check_eq("rst_clean", clean, 0);
        check_eq("rst_press", press, 0);
        check_eq("rst_release", release_pulse, 0);
        check_eq("rst_scan_idx", scan_idx, 0);
        check_eq("rst_running", running, 0);
`ifdef BTN_EVENT_LATCH_EN
        check_eq("rst_evt_pend", evt_pend, 0);
`endif
        reset = 1'b0;

        step();
        check_eq("settle_clk1_running", running, 0);
        step();
        check_eq("settle_clk2_running", running, 0);
        step();
        check_eq("run_entry_running", running, 1);
        rc = 1;

        // Clean press on ch1, bounce on ch2, then ch0 press and ch0-release/ch3-press together.
        while (rc <= 270) begin
            if (rc <= 17 && (rc - 1) % 4 == 0)
                check_eq($sformatf("scan_idx_rc%0d", rc), scan_idx, ((rc - 1) / 4) % 4);
            if (rc == 17) check_eq("idle_outputs_clean", clean, 0);
            if (rc == 40) check_eq("ch1_clean_before", clean[1], 0);
            if (rc == 41) begin
                check_eq("ch1_clean_after", clean[1], 1);
                check_eq("ch1_press_high", press[1], 1);
            end
            if (rc == 42) check_eq("ch1_press_one_cycle", press[1], 0);
            if (rc >= 4 && rc <= 148 && (rc - 4) % 16 == 0)
                raw[2] = (((rc - 4) / 16) % 2 == 0);
            if (rc == 161) raw[0] = 1'b1;
            if (rc == 209) begin
                raw[0] = 1'b0;
                raw[3] = 1'b1;
            end
            step();
        end

        check_eq("ch2_bounce_clean", clean[2], 0);
        check_eq("ch2_bounce_press", press_cnt[2], 0);
        check_eq("ch2_bounce_release", rel_cnt[2], 0);
        check_eq("ch1_press_count", press_cnt[1], 1);
        check_eq("ch1_press_at", press_at[1], 41);
        check_eq("ch0_press_at", press_at[0], 197);
        check_eq("ch0_release_count", rel_cnt[0], 1);
        check_eq("ch0_release_at", rel_at[0], 245);
        check_eq("ch3_press_count", press_cnt[3], 1);
        check_eq("ch3_press_at", press_at[3], 257);
        check_eq("no_coincident_pulses", coincide, 0);
        check_eq("clean_after_simul", clean, 4'b1010);
`ifdef BTN_EVENT_LATCH_EN
        check_eq("evt_pend_after_presses", evt_pend, 4'b1011);
`endif

        // Drop en while ch1 has two disagreeing visits accumulated.
        while (rc <= 300) begin
            if (rc == 273) raw[1] = 1'b0;
            if (rc == 300) en = 1'b0;
            step();
        end
        check_eq("en_drop_running", running, 0);
        check_eq("en_drop_scan_idx", scan_idx, 0);
        check_eq("en_drop_clean_held", clean[1], 1);
        repeat (3) step();
        check_eq("idle_running", running, 0);
`ifdef BTN_EVENT_LATCH_EN
        check_eq("evt_pend_kept_in_idle", evt_pend, 4'b1011);
`endif

        en = 1'b1;
        step();
        step();
        check_eq("resettle_running", running, 0);
        step();
        check_eq("rerun_running", running, 1);
        rc = 1;

        while (rc <= 100) begin
            if (rc == 9)  check_eq("ch1_no_early_release", clean[1], 1);
            if (rc == 40) check_eq("ch1_clean_before_release", clean[1], 1);
            if (rc == 41) begin
                check_eq("ch1_clean_released", clean[1], 0);
                check_eq("ch1_release_high", release_pulse[1], 1);
            end
            if (rc == 49) raw[1] = 1'b1;
`ifdef BTN_EVENT_LATCH_EN
            if (rc == 10) evt_ack[1] = 1'b1;
            if (rc == 11) begin
                evt_ack[1] = 1'b0;
                check_eq("evt_ack_clears", evt_pend[1], 0);
            end
            if (rc == 88) check_eq("evt_pend_before_repress", evt_pend[1], 0);
            if (rc == 89) begin
                check_eq("ch1_repress_high", press[1], 1);
                evt_ack[1] = 1'b1;
            end
            if (rc == 90) begin
                evt_ack[1] = 1'b0;
                check_eq("evt_set_wins", evt_pend[1], 1);
            end
            if (rc == 95) evt_ack[1] = 1'b1;
            if (rc == 96) begin
                evt_ack[1] = 1'b0;
                check_eq("evt_late_ack", evt_pend, 4'b1001);
            end
`endif
            step();
        end

        check_eq("ch1_release_count", rel_cnt[1], 1);
        check_eq("ch1_release_at", rel_at[1], 41);
        check_eq("ch1_repress_count", press_cnt[1], 2);
        check_eq("ch1_repress_at", press_at[1], 89);
        check_eq("no_coincident_final", coincide, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_scan_ctrl.md
Name: btn_scan_ctrl

Overview:
- Scheduler that shares one debounce evaluator across N_BTN raw pushbutton inputs, visiting them round-robin.
- Visits are paced by a prescaled tick.
- Produces per-channel clean levels plus one-cycle press/release pulses that feed downstream sequence-detector FSMs.
- Replaces N free-running per-button debouncers with one time-multiplexed datapath and a small control FSM.

Parameters:
- N_BTN, 4, number of raw button channels (2..16).
- TICK_DIV, 1000, clocks between channel visits (>=2).
- DB_CNT, 8, consecutive disagreeing samples required to accept a level change (2..255).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  scan enable
- raw  in  N_BTN  asynchronous button levels
- clean  out  N_BTN  debounced levels
- press  out  N_BTN  one-cycle pulse on accepted 0->1
- release  out  N_BTN  one-cycle pulse on accepted 1->0
- scan_idx  out  clog2(N_BTN)  channel evaluated on the current tick
- running  out  1  high in RUN state

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Ports are named clk and reset.
- Reset values: clean=0, press=0, release=0, scan_idx=0, running=0. Internally: prescaler=0, all channel counters=0, synchronizer flops=0, state=IDLE.
- Synchronization: raw passes through a 2-flop synchronizer per bit, clocked every cycle regardless of state. sraw is the synchronizer output.
- FSM IDLE: all counters held at 0.
  - en=1 -> SETTLE.
- FSM SETTLE: runs exactly 2 clocks so the synchronizer can fill.
  - en=0 at any point -> IDLE.
  - Otherwise -> RUN.
- FSM RUN: prescaler counts 0..TICK_DIV-1. tick = (prescaler==TICK_DIV-1).
  - en=0 -> IDLE. Prescaler, scan_idx and all channel counters clear; clean is held.
- Evaluation on tick, for channel i=scan_idx:
  - sraw[i]==clean[i]: cnt[i]<=0.
  - Otherwise, if cnt[i]==DB_CNT-1: clean[i] toggles, cnt[i]<=0, and the matching press[i] or release[i] is high for exactly the next cycle.
  - Otherwise: cnt[i]<=cnt[i]+1.
- scan_idx advances on every tick and wraps from N_BTN-1 to 0. Each channel is visited every N_BTN*TICK_DIV clocks.
- Acceptance latency: DB_CNT visits of a stable new level. A single disagreeing sample followed by an agreeing one restarts the count from 0.
- Widths: counter width is clog2(DB_CNT). Prescaler width is clog2(TICK_DIV). No counter may overflow.
- Simultaneous changes: multiple channels may change together. Each is accepted on its own visit, so pulses never coincide within one cycle.
- Reset mid-operation: takes effect immediately. Any in-flight pulse is dropped.
- running is registered and equals (state==RUN).

Optional Feature:
- Macro: BTN_EVENT_LATCH_EN.
- Defined:
  - Adds input evt_ack[N_BTN] and output evt_pend[N_BTN], reset 0.
  - press[i] sets evt_pend[i]. evt_ack[i] clears it.
  - If set and clear occur in the same cycle, set wins.
  - Leaving RUN does not clear evt_pend.
- Undefined: these ports and this logic are absent. All other behaviour is identical.

Decomposition:
- Package btn_scan_pkg: state encoding (IDLE=0, SETTLE=1, RUN=2), SETTLE_CYCLES=2, and a width-helper constant function.
- Sub-module sync_2ff: parameterized width, 2-stage synchronizer instantiated once for the raw vector.
- The evaluator and FSM stay in the top module.

Test Plan (all with N_BTN=4, TICK_DIV=4, DB_CNT=3; channel 1 is visited at RUN cycles 8, 24, 40, ...):
1. Power-up: reset high, then low with en=1 and raw=0 -> SETTLE lasts 2 clocks, then running=1. Outputs stay 0; scan_idx sequences 0,1,2,3,0 every 4 clocks.
2. Clean press: raw[1]=1 steadily from reset release -> clean[1] rises after the 3rd visit of channel 1, at RUN cycle 40. press[1] is high for exactly 1 cycle. No other channel changes.
3. Bounce reject: raw[2] toggles 1,0 on alternating channel-2 visits for 10 visits -> clean[2] stays 0, with no press or release pulse.
4. Release plus simultaneous activity: clean[0]=1 and clean[3]=0. At one clock, raw[0] goes to 0 and raw[3] goes to 1, both held -> release[0] and press[3] each pulse once, 12 clocks apart, never in the same cycle.
5. Enable drop: en=0 midway through channel 1 accumulating (cnt=2) -> state is IDLE within 1 cycle and scan_idx=0. After en=1 resumes, 3 full visits are needed again before acceptance.
6. BTN_EVENT_LATCH_EN: press[1] sets evt_pend[1]. evt_ack[1] pulsed in the same cycle as a new press keeps evt_pend[1]=1. A later ack alone clears it.
